// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the two-requester memory port arbiter.
package mem_port_arbiter_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
    } mem_req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        err;
    } mem_rsp_t;

    typedef enum logic {
        MEM_PORT_IF = 1'b0,
        MEM_PORT_D  = 1'b1
    } mem_port_e;

    localparam int CNT_W = 4;

    // Word index is addr[31:2]; the two byte-offset bits never affect the range.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input int unsigned depth);
        return {2'b00, addr[31:2]} < depth;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Counts consecutive conflicts IF has lost; saturates at STARVE_LIMIT.
import mem_port_arbiter_pkg::*;

module arb_starve_counter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    logic [CNT_W-1:0] cnt;

    // Clear wins over increment; hold once the limit is reached.
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc && (cnt != CNT_W'(STARVE_LIMIT)))
            cnt <= cnt + 1'b1;
    end

    assign at_limit = (cnt == CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between instruction fetch and
// load/store. D has fixed priority; IF is forced through after
// STARVE_LIMIT lost conflicts. Responses are registered, one cycle later.
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
    parameter int DEPTH_WORDS  = 255,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_rerr,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_we,
    output logic        d_ready,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_rerr,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

    mem_req_t  d_cmd;
    mem_rsp_t  if_rsp, d_rsp;
    mem_port_e sel, last_sel;
    logic      gnt_if, gnt_d, at_limit;
    logic      if_in_range, d_in_range;

    assign d_cmd       = '{addr: d_addr, wdata: d_wdata, we: d_we};
    assign if_in_range = addr_in_range(if_addr, DEPTH_WORDS);
    assign d_in_range  = addr_in_range(d_cmd.addr, DEPTH_WORDS);

    // Grant: D unless IF has hit its starvation cap; nothing during reset.
    always_comb begin
        gnt_if = 1'b0;
        gnt_d  = 1'b0;
        if (!rst) begin
            if (d_req && !(if_req && at_limit))
                gnt_d = 1'b1;
            else if (if_req)
                gnt_if = 1'b1;
        end
    end

    // Idle cycles keep the previous select so the address bus does not toggle.
    always_comb begin
        sel = last_sel;
        if (gnt_d)
            sel = MEM_PORT_D;
        else if (gnt_if)
            sel = MEM_PORT_IF;
    end

    // Remember the last port that drove the memory.
    always_ff @(posedge clk) begin
        if (rst)
            last_sel <= MEM_PORT_IF;
        else
            last_sel <= sel;
    end

    // Counts only real conflicts lost by IF; any cycle without an IF request
    // or with an IF grant restarts the window.
    arb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (if_req & gnt_d),
        .clr      (gnt_if | ~if_req),
        .at_limit (at_limit)
    );

    assign if_ready         = gnt_if;
    assign d_ready          = gnt_d;
    assign mem_address      = (sel == MEM_PORT_D) ? d_cmd.addr : if_addr;
    assign mem_write_data   = d_cmd.wdata;
    assign mem_write_enable = gnt_d & d_cmd.we & d_in_range;

    // Capture read data of the granted port; out-of-range reads return 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rsp <= '0;
            d_rsp  <= '0;
        end else begin
            if_rsp.valid <= gnt_if;
            d_rsp.valid  <= gnt_d;
            if (gnt_if) begin
                if_rsp.rdata <= if_in_range ? mem_read_data : 32'h0;
                if_rsp.err   <= ~if_in_range;
            end
            if (gnt_d) begin
                d_rsp.rdata <= d_in_range ? mem_read_data : 32'h0;
                d_rsp.err   <= ~d_in_range;
            end
        end
    end

    assign if_rvalid = if_rsp.valid;
    assign if_rdata  = if_rsp.rdata;
    assign if_rerr   = if_rsp.err;
    assign d_rvalid  = d_rsp.valid;
    assign d_rdata   = d_rsp.rdata;
    assign d_rerr    = d_rsp.err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized + directed bench for mem_port_arbiter with a word-array
// reference model and per-port response scoreboards.
module tb_mem_port_arbiter;

    localparam int DEPTH  = 255;
    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic        if_ready, if_rvalid, if_rerr, d_ready, d_rvalid, d_rerr;
    logic [31:0] if_rdata, d_rdata, mem_address, mem_write_data, mem_read_data;
    logic        mem_write_enable;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.DEPTH_WORDS(DEPTH), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_rerr(if_rerr),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rerr(d_rerr),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Physical memory: combinational read, posedge write. Larger than DEPTH
    // so out-of-range addresses still alias onto real storage.
    logic [31:0] mem [0:511];
    assign mem_read_data = mem[mem_address[10:2]];
    always @(posedge clk) if (mem_write_enable) mem[mem_address[10:2]] <= mem_write_data;

    // Reference model state
    logic [31:0] ref_mem [0:511];
    typedef struct { int c; logic [31:0] d; logic e; } exp_t;
    exp_t if_q[$];
    exp_t d_q[$];
    int   cyc  = 0;
    int   lose = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic in_rng(input logic [31:0] a);
        return (a >> 2) < 32'(DEPTH);
    endfunction

    // Monitor + model, sampled mid-cycle when inputs and combinational outputs are stable.
    always @(negedge clk) begin
        logic gi, gd, exp_v;
        exp_t x;
        cyc = cyc + 1;

        exp_v = (if_q.size() > 0) && (if_q[0].c == cyc - 1);
        chk("if_rvalid", 32'(if_rvalid), 32'(exp_v));
        if (exp_v) begin
            x = if_q.pop_front();
            chk("if_rdata", if_rdata, x.d);
            chk("if_rerr", 32'(if_rerr), 32'(x.e));
        end
        exp_v = (d_q.size() > 0) && (d_q[0].c == cyc - 1);
        chk("d_rvalid", 32'(d_rvalid), 32'(exp_v));
        if (exp_v) begin
            x = d_q.pop_front();
            chk("d_rdata", d_rdata, x.d);
            chk("d_rerr", 32'(d_rerr), 32'(x.e));
        end

        // IF loses at most STARVE conflicts in a row, then gets one.
        gi = 1'b0;
        gd = 1'b0;
        if (rst) lose = 0;
        else if (d_req && if_req) begin
            if (lose == STARVE) begin gi = 1'b1; lose = 0; end
            else begin gd = 1'b1; lose++; end
        end else if (d_req) begin gd = 1'b1; lose = 0; end
        else if (if_req) begin gi = 1'b1; lose = 0; end
        else lose = 0;

        chk("if_ready", 32'(if_ready), 32'(gi));
        chk("d_ready", 32'(d_ready), 32'(gd));
        chk("mem_we", 32'(mem_write_enable), 32'(gd & d_we & in_rng(d_addr)));

        if (gi) begin
            chk("if_mem_addr", mem_address, if_addr);
            x.c = cyc;
            x.e = !in_rng(if_addr);
            x.d = x.e ? 32'h0 : ref_mem[if_addr[10:2]];
            if_q.push_back(x);
        end
        if (gd) begin
            chk("d_mem_addr", mem_address, d_addr);
            x.c = cyc;
            x.e = !in_rng(d_addr);
            x.d = x.e ? 32'h0 : ref_mem[d_addr[10:2]];
            d_q.push_back(x);
            if (d_we && !x.e) ref_mem[d_addr[10:2]] = d_wdata;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic if_access(input logic [31:0] a);
        int n = 0;
        if_req  = 1'b1;
        if_addr = a;
        do begin @(negedge clk); n++; end while (!if_ready && n < 60);
        if (!if_ready) begin
            total++; bad++;
            $display("FAIL if_timeout: got no accept want accept for %h", a);
        end
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic d_access(input logic [31:0] a, input logic [31:0] wd, input logic we);
        int n = 0;
        d_req = 1'b1; d_addr = a; d_wdata = wd; d_we = we;
        do begin @(negedge clk); n++; end while (!d_ready && n < 60);
        if (!d_ready) begin
            total++; bad++;
            $display("FAIL d_timeout: got no accept want accept for %h", a);
        end
        @(posedge clk); #1;
        d_req = 1'b0; d_we = 1'b0;
    endtask

    function automatic logic [31:0] rnd_addr();
        case ($urandom_range(0, 9))
            0: return 32'h3FC;
            1: return 32'h3F8;
            2: return 32'h8000_0000 | ($urandom & 32'hFFF);
            3: return 32'h400;
            default: return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = $urandom;
        mem[0] = 32'hDEADBEEF;
        mem[1] = 32'h12345678;
        mem[2] = 32'hABCDEF01;
        for (int i = 0; i < 512; i++) ref_mem[i] = mem[i];

        idle(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_if_rerr", 32'(if_rerr), 32'h0);
        chk("rst_d_rerr", 32'(d_rerr), 32'h0);
        @(posedge clk); #1;

        // Single IF read, then D write/read-back of word 2
        if_access(32'h0);
        idle(1);
        d_access(32'h8, 32'h55AA55AA, 1'b1);
        d_access(32'h8, 32'h0, 1'b0);
        idle(1);

        // Sustained conflict: D four times, then IF
        fork
            repeat (2) if_access(32'h4);
            repeat (10) d_access(32'h50, $urandom, 1'b0);
        join
        idle(1);

        // Out-of-range write must not land anywhere; word 0 unchanged
        d_access(32'h3FC, 32'hFFFF_0000, 1'b1);
        if_access(32'h0);
        idle(1);

        // Reset in the middle of a conflict with a response in flight
        fork
            if_access(32'h4);
            repeat (7) d_access(32'h50, $urandom, 1'b1);
            begin idle(3); rst = 1'b1; idle(1); rst = 1'b0; end
        join
        idle(2);

        // Random traffic on both ports
        fork
            repeat (150) begin
                if_access(rnd_addr());
                idle($urandom_range(0, 2));
            end
            repeat (150) begin
                d_access(rnd_addr(), $urandom, 1'($urandom_range(0, 1)));
                idle($urandom_range(0, 2));
            end
        join
        idle(3);

        chk("if_q_drained", 32'(if_q.size()), 32'h0);
        chk("d_q_drained", 32'(d_q.size()), 32'h0);
        chk("mem_word0", mem[0], ref_mem[0]);
        chk("mem_word254", mem[254], ref_mem[254]);
        chk("mem_word255_untouched", mem[255], ref_mem[255]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port word memory (combinational read, write on posedge) between two requesters: instruction fetch (IF port) and load/store (D port).
- Grants one access per cycle. D port has fixed priority, with an anti-starvation cap for IF.
- Registers one-cycle responses back to each requester.
- Sits between the core pipeline and the memory block. Drives the memory's address, write_data and write_enable; samples its read_data.

Parameters:
- DEPTH_WORDS, 255: number of valid 32-bit words in the memory. Word index = addr[31:2].
- STARVE_LIMIT, 4: maximum number of consecutive cycles IF may lose arbitration before it is forced a grant. Range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  IF request valid. Must be held with if_addr stable until if_ready.
- if_addr  in  32  IF byte address.
- if_ready  out  1  IF request accepted this cycle (combinational).
- if_rvalid  out  1  IF response valid (registered).
- if_rdata  out  32  IF read data.
- if_rerr  out  1  IF access was out of range.
- d_req  in  1  D request valid. Must be held with fields stable until d_ready.
- d_addr  in  32  D byte address.
- d_wdata  in  32  D write data.
- d_we  in  1  D write (1) / read (0).
- d_ready  out  1  D request accepted this cycle.
- d_rvalid  out  1  D response valid.
- d_rdata  out  32  D read data (old contents on a write).
- d_rerr  out  1  D access was out of range.
- mem_address  out  32  to memory address.
- mem_write_data  out  32  to memory write_data.
- mem_write_enable  out  1  to memory write_enable.
- mem_read_data  in  32  from memory read_data.

Behaviour:
- Reset (rst=1 at posedge):
  - if_rvalid, d_rvalid, if_rerr, d_rerr = 0.
  - if_rdata, d_rdata = 0.
  - starve counter = 0.
- While rst=1, if_ready, d_ready and mem_write_enable are forced to 0 combinationally, so no access is accepted or written in a reset cycle.
- Grant (combinational, per cycle):
  - Only d_req: grant D.
  - Only if_req: grant IF.
  - Both, counter < STARVE_LIMIT: grant D; counter increments.
  - Both, counter == STARVE_LIMIT: grant IF; counter clears.
  - Counter also clears on any IF grant, or when if_req=0.
  - Neither request: no grant. mem_write_enable=0; mem_address holds its last driven value (registered mux select is acceptable).
- Acceptance:
  - xx_ready=1 exactly in the grant cycle N.
  - The memory is addressed by the granted port in cycle N.
  - mem_write_enable = d_we & D granted & in range.
- Range check: in range = (addr[31:2] < DEPTH_WORDS). Out-of-range accesses:
  - Are still accepted.
  - Suppress the write.
  - Respond with xx_rerr=1 and xx_rdata=0.
- Response latency is 1 cycle:
  - At the posedge ending cycle N, the granted port's rvalid=1 and rdata = mem_read_data sampled in N (pre-write contents for a D write).
  - rvalid is a single-cycle pulse unless a new grant occurs in N+1.
  - Back-to-back accepts give back-to-back rvalid.
  - The non-granted port's rvalid=0.
- Low address bits [1:0] are ignored (word access only). No misalignment trap in this block.
- Reset mid-operation: a response pending from the cycle before reset is dropped (rvalid=0 after the reset edge). Requesters re-issue.
- No internal queueing. Each port has at most one outstanding request; no ordering hazards.

Decomposition:
- Additions to the shared riscv_structures package:
  - mem_req_t struct {addr[31:0], wdata[31:0], we}.
  - mem_rsp_t struct {valid, rdata[31:0], err}.
  - mem_port_e enum {MEM_PORT_IF, MEM_PORT_D}.
- One natural sub-module: arb_starve_counter. Saturating 4-bit counter with inc/clr inputs and an at_limit output, parameterised by STARVE_LIMIT.
- Grant mux and response registers stay in mem_port_arbiter.

Test Plan:
- Reset release, then IF read at 0x0 only -> if_ready in the same cycle; next cycle if_rvalid=1, if_rdata=0xDEADBEEF, d_rvalid=0.
- D write 0x55AA55AA to 0x8, then D read 0x8 -> first response d_rdata=0xABCDEF01 (old value); second d_rdata=0x55AA55AA.
- Both requesting continuously (IF addr 0x4, D addr 0x50) -> D granted 4 cycles, IF on the 5th with if_rdata=0x12345678; pattern repeats every 5 cycles with no gaps in rvalid.
- D write to 0x3FC (word 255, out of range) -> mem_write_enable never 1, d_rerr=1, d_rdata=0; a subsequent read of 0x0 is unchanged at 0xDEADBEEF.
- rst asserted with both reqs high and a pending response -> ready=0 and mem_write_enable=0 in the reset cycle; rvalid=0 after the edge; counter restarts at 0 (D wins the first 4 conflicts afterward).
